cmp_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered magnitude comparator among `N` requesters. Each requester presents an operand pair and raises `req`. The block grants one requester at a time, captures its operands, and runs the compare. It then returns a tagged less/greater/equal result over a valid/ready response channel. It sits between the per-channel clients and the comparator datapath, so only one comparator is instantiated for the whole cluster.

---
 rtl/cmp_pkg.sv | 12 +
 rtl/mag_cmp.sv | 19 +
 rtl/cmp_share_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the shared-comparator arbiter: FSM state and the packed compare result.
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, CMP, RESP} cmp_state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/mag_cmp.sv
// Purely combinational unsigned magnitude comparator; exactly one result flag is set.
module mag_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output cmp_res_t     res_o
);

    always_comb begin
        res_o    = '0;
        res_o.lt = (a_i < b_i);
        res_o.gt = (a_i > b_i);
        res_o.eq = (a_i == b_i);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one registered magnitude comparator among N
// requesters and returns a tagged lt/gt/eq result over a valid/ready channel.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_lt,
    output logic             rsp_gt,
    output logic             rsp_eq
);

    cmp_state_t     state_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] cur_id_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [N-1:0]   gnt_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    cmp_res_t       rsp_q;

    cmp_res_t       cmp_res;
    logic [IDW-1:0] win_c;
    logic [W-1:0]   a_sel_c;
    logic [W-1:0]   b_sel_c;

    // Rotate so the search starts after the last winner, take the lowest set bit, rotate back.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] last);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int unsigned    start;
        int unsigned    off;
        logic           found;
        start = (32'(last) + 32'd1) % N;
        dbl   = {r, r};
        rot   = N'(dbl >> start);
        off   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = i;
                found = 1'b1;
            end
        end
        return IDW'((start + off) % N);
    endfunction

    assign win_c = rr_pick(req, last_q);

    // Operand mux for the round-robin winner.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IDW'(i) == win_c) begin
                a_sel_c = a_in[i*W +: W];
                b_sel_c = b_in[i*W +: W];
            end
        end
    end

    mag_cmp #(.W(W)) u_mag_cmp (
        .a_i   (a_q),
        .b_i   (b_q),
        .res_o (cmp_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDW'(N - 1);
            cur_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        a_q      <= a_sel_c;
                        b_q      <= b_sel_c;
                        cur_id_q <= win_c;
                        last_q   <= win_c;
                        gnt_q    <= N'(1) << win_c;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    rsp_q       <= cmp_res;
                    rsp_id_q    <= cur_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Flags drop with valid so they never read as a stale result.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_lt    = rsp_q.lt;
    assign rsp_gt    = rsp_q.gt;
    assign rsp_eq    = rsp_q.eq;

endmodule
